// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR filter with a single multiplier.
// A sample is accepted in IDLE. MAC then walks one tap per cycle.
// OUT holds the result until the downstream handshake.
// Optional macro FIR_TDM_SATURATE_EN: when defined, the shifted result
// saturates to the signed WIDTH range. When undefined, it wraps to the
// low WIDTH bits.
module fir_tdm #(
    parameter int WIDTH   = 8,
    parameter int TAPS    = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    data_out,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [WIDTH-1:0]    coef_wdata,
    input  logic [SHIFT_W-1:0]         shift
);

    localparam int CW = $clog2(TAPS);
    localparam int PW = 2 * WIDTH;
    // Accumulator width: a full-width product plus clog2(TAPS) guard bits,
    // so that summing TAPS products cannot overflow.
    localparam int AW = PW + CW;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [WIDTH-1:0]  r_x    [TAPS];
    logic signed [WIDTH-1:0]  r_coef [TAPS];
    logic signed [AW-1:0]     r_acc;
    logic [CW-1:0]            r_tap;
    logic [SHIFT_W-1:0]       r_shift;
    logic signed [WIDTH-1:0]  r_data_out;
    logic                     r_out_valid;

    logic                     w_accept;
    logic signed [PW-1:0]     w_prod;
    logic signed [AW-1:0]     w_acc_sum;
    logic signed [WIDTH-1:0]  w_post;
`ifdef FIR_TDM_SATURATE_EN
    logic signed [AW-1:0]     w_shifted;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    // in_ready is forced low during reset so no sample can slip in.
    assign in_ready  = (r_state == IDLE) && enable && !reset;
    assign w_accept  = in_valid && in_ready;
    assign w_prod    = r_coef[r_tap] * r_x[r_tap];
    // The partial sum includes the current tap, so the last MAC cycle can
    // load data_out directly.
    assign w_acc_sum = r_acc + AW'(w_prod);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

    // Post-process the final sum: arithmetic shift, then saturate or wrap.
    always_comb begin
`ifdef FIR_TDM_SATURATE_EN
        w_shifted = w_acc_sum >>> r_shift;
        if (w_shifted > SAT_MAX) begin
            w_post = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_post = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_post = w_shifted[WIDTH-1:0];
        end
`else
        w_post = WIDTH'(w_acc_sum >>> r_shift);
`endif
    end

    // Next-state logic; dropping enable returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = w_accept ? MAC : IDLE;
                MAC:     w_state_next = (r_tap == LAST_TAP) ? OUT : MAC;
                OUT:     w_state_next = out_ready ? IDLE : OUT;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: delay line, coefficients, accumulator, tap counter and output.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= '0;
            end
            r_acc       <= '0;
            r_tap       <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Coefficient writes land only in IDLE. A write in the acceptance
            // cycle is therefore seen by that sample's first MAC cycle.
            if (coef_we && (r_state == IDLE)) begin
                r_coef[coef_addr] <= coef_wdata;
            end
            if (!enable) begin
                // Flush: clear the history and output, but keep the coefficients.
                for (int k = 0; k < TAPS; k++) begin
                    r_x[k] <= '0;
                end
                r_acc       <= '0;
                r_tap       <= '0;
                r_data_out  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            for (int k = 1; k < TAPS; k++) begin
                                r_x[k] <= r_x[k-1];
                            end
                            r_x[0]  <= data_in;
                            r_acc   <= '0;
                            r_tap   <= '0;
                            r_shift <= shift;
                        end
                    end
                    MAC: begin
                        r_acc <= w_acc_sum;
                        r_tap <= r_tap + {{(CW-1){1'b0}}, 1'b1};
                        if (r_tap == LAST_TAP) begin
                            r_data_out  <= w_post;
                            r_out_valid <= 1'b1;
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm.sv
// Self-checking bench for fir_tdm (WIDTH=8, TAPS=4).
// A behavioural model computes each result as a plain sum of products over
// the sample history. A negedge compare process checks every cycle against
// that model, and directed tests pin the model with literal values.
module tb_fir_tdm;

    localparam int W    = 8;
    localparam int TAPS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] data_out;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_wdata;
    logic [4:0]        shift;

    int checks   = 0;
    int failures = 0;

    fir_tdm #(.WIDTH(8), .TAPS(4), .SHIFT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .shift      (shift)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_coef [TAPS];
    int     m_hist [TAPS];
    int     m_cnt     = 0;
    bit     m_valid   = 1'b0;
    int     m_data    = 0;
    int     m_pend    = 0;
    bit     m_started = 1'b0;
    bit     m_idle;
    longint m_acc;

    function automatic int post(input longint v);
`ifdef FIR_TDM_SATURATE_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
`else
        logic signed [7:0] b;
        b = v[7:0];
        return int'(b);
`endif
    endfunction

    // Model update at each rising edge, using the inputs held over that edge.
    always begin
        @(posedge clk);
        if (reset) begin
            m_started = 1'b1;
            for (int i = 0; i < TAPS; i++) begin
                m_coef[i] = 0;
                m_hist[i] = 0;
            end
            m_cnt = 0; m_valid = 1'b0; m_data = 0;
        end else begin
            m_idle = (m_cnt == 0) && !m_valid;
            if (m_idle && coef_we) m_coef[coef_addr] = int'(coef_wdata);
            if (!enable) begin
                for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
                m_cnt = 0; m_valid = 1'b0; m_data = 0;
            end else if (m_idle && in_valid) begin
                for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = int'(data_in);
                m_acc = 0;
                for (int i = 0; i < TAPS; i++) m_acc += longint'(m_coef[i]) * longint'(m_hist[i]);
                m_acc  = m_acc >>> shift;
                m_pend = post(m_acc);
                m_cnt  = TAPS;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_pend;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, on the falling edge.
    always begin
        @(negedge clk);
        if (m_started) begin
            check("out_valid", int'(out_valid), int'(m_valid));
            check("data_out", int'(data_out), m_data);
            check("in_ready", int'(in_ready), int'(m_idle_now()));
        end
    end

    function automatic bit m_idle_now();
        return (m_cnt == 0) && !m_valid && enable && !reset;
    endfunction

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we = 1'b1; coef_addr = 2'(a); coef_wdata = 8'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic flush();
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    // Present one sample, optionally with a same-cycle coefficient write.
    // Waits (bounded) for out_valid, returns data_out and the cycles taken,
    // then completes the handshake if out_ready is high.
    task automatic send(input int x, input int sh, input bit we, input int a,
                        input int wd, output int res, output int lat);
        data_in = 8'(x); shift = 5'(sh); in_valid = 1'b1;
        coef_we = we; coef_addr = 2'(a); coef_wdata = 8'(wd);
        tick();
        in_valid = 1'b0; coef_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) check("valid_timeout", int'(out_valid), 1);
        res = int'(data_out);
        if (out_ready) tick();
    endtask

    int res, lat;
    int outs [4];
    int seen;

    initial begin
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data_in = 8'sd0; coef_we = 1'b0; coef_addr = 2'd0; coef_wdata = 8'sd0;
        shift = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Impulse response with coefs 1,2,3,4.
        for (int i = 0; i < 4; i++) wr_coef(i, i + 1);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 1 : 0, 0, 1'b0, 0, 0, outs[i], lat);
            if (i == 0) check("latency_ticks", lat, 4);
        end
        for (int i = 0; i < 4; i++) check("impulse", outs[i], i + 1);

        // Backpressure: result held for three cycles with in_ready low.
        flush();
        out_ready = 1'b0;
        send(5, 0, 1'b0, 0, 0, res, lat);
        check("bp_value", res, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", int'(data_out), 5);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);

        // Overflow: all coefs 127, four inputs of 127.
        for (int i = 0; i < 4; i++) wr_coef(i, 127);
        flush();
        for (int i = 0; i < 4; i++) send(127, 0, 1'b0, 0, 0, outs[i], lat);
`ifdef FIR_TDM_SATURATE_EN
        check("ovf_first", outs[0], 127);
        check("ovf_fourth", outs[3], 127);
`else
        check("ovf_first", outs[0], 1);
        check("ovf_fourth", outs[3], 4);
`endif

        // Shift and sign cases.
        wr_coef(0, 64);
        for (int i = 1; i < 4; i++) wr_coef(i, 0);
        flush();
        send(100, 6, 1'b0, 0, 0, res, lat);
        check("shift6", res, 100);
        wr_coef(0, 1);
        flush();
        send(-3, 1, 1'b0, 0, 0, res, lat);
        check("neg_floor", res, -2);

        // A write in the acceptance cycle is used for that sample.
        flush();
        send(2, 0, 1'b1, 0, 9, res, lat);
        check("same_cycle_wr", res, 18);

        // Flush in the 2nd MAC cycle: no output is produced.
        for (int i = 0; i < 4; i++) wr_coef(i, i + 1);
        flush();
        data_in = 8'sd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        check("flush_valid", int'(out_valid), 0);
        check("flush_data", int'(data_out), 0);
        enable = 1'b1;
        #1;
        check("flush_idle", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_no_output", seen, 0);

        // A write during MAC is ignored.
        data_in = 8'sd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wr_coef(0, 99);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check("mac_wr_result", int'(data_out), 1);
        tick();
        flush();
        send(1, 0, 1'b0, 0, 0, res, lat);
        check("mac_wr_ignored", res, 1);

        // Reset during OUT clears everything, including the coefficients.
        flush();
        out_ready = 1'b0;
        send(3, 0, 1'b0, 0, 0, res, lat);
        check("pre_reset_value", res, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_out_valid2", int'(out_valid), 0);
        check("rst_data_out2", int'(data_out), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send((i == 0) ? 1 : 0, 0, 1'b0, 0, 0, outs[i], lat);
        for (int i = 0; i < 4; i++) check("post_reset_impulse", outs[i], 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
